// File: rtl/sdram_arbit_pkg.sv
// sdram_arbit_pkg: shared SDRAM command codes and arbiter state encoding
package sdram_arbit_pkg;
    // {cs_n, ras_n, cas_n, we_n}
    localparam logic [3:0] CMD_LOAD_MODE = 4'b0000;
    localparam logic [3:0] CMD_AREF      = 4'b0001;
    localparam logic [3:0] CMD_PRECHARGE = 4'b0010;
    localparam logic [3:0] CMD_ACTIVE    = 4'b0011;
    localparam logic [3:0] CMD_WRITE     = 4'b0100;
    localparam logic [3:0] CMD_READ      = 4'b0101;
    localparam logic [3:0] CMD_NOP       = 4'b0111;

    typedef enum logic [2:0] {
        ST_INIT  = 3'd0,
        ST_ARBIT = 3'd1,
        ST_AREF  = 3'd2,
        ST_WRITE = 3'd3,
        ST_READ  = 3'd4
    } state_t;
endpackage

// File: rtl/sdram_arbit.sv
// sdram_arbit: fixed-priority SDRAM bus arbiter (refresh > write > read) with command/address/data mux
// Ports:
//   clk, rstn                      clock, async active-low reset
//   init_end, init_cmd/init_addr   init master: done flag, command, {ba,addr}
//   aref_req/aref_end, aref_cmd/aref_addr  refresh master
//   wr_req/wr_end, wr_cmd/wr_addr, wr_dq_oe/wr_dq  write master
//   rd_req/rd_end, rd_cmd/rd_addr  read master
//   aref_en/wr_en/rd_en            registered grants
//   sdram_cke, sdram_cmd/sdram_addr, sdram_dq_oe/sdram_dq  device-side mux outputs
module sdram_arbit #(
    parameter logic [3:0] CMD_NOP = sdram_arbit_pkg::CMD_NOP
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        init_end,
    input  logic [3:0]  init_cmd,
    input  logic [14:0] init_addr,
    input  logic        aref_req,
    input  logic        aref_end,
    input  logic [3:0]  aref_cmd,
    input  logic [14:0] aref_addr,
    input  logic        wr_req,
    input  logic        wr_end,
    input  logic [3:0]  wr_cmd,
    input  logic [14:0] wr_addr,
    input  logic        wr_dq_oe,
    input  logic [15:0] wr_dq,
    input  logic        rd_req,
    input  logic        rd_end,
    input  logic [3:0]  rd_cmd,
    input  logic [14:0] rd_addr,
    output logic        aref_en,
    output logic        wr_en,
    output logic        rd_en,
    output logic        sdram_cke,
    output logic [3:0]  sdram_cmd,
    output logic [14:0] sdram_addr,
    output logic        sdram_dq_oe,
    output logic [15:0] sdram_dq
);
    import sdram_arbit_pkg::*;

    state_t state_q, state_d;
    logic   aref_en_q, wr_en_q, rd_en_q;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q   <= ST_INIT;
            aref_en_q <= 1'b0;
            wr_en_q   <= 1'b0;
            rd_en_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            aref_en_q <= state_d == ST_AREF;
            wr_en_q   <= state_d == ST_WRITE;
            rd_en_q   <= state_d == ST_READ;
        end
    end

    // Next state and device mux; the mux follows the registered state so that
    // reset immediately hands the bus back to the init master.
    always_comb begin
        state_d     = state_q;
        sdram_cmd   = CMD_NOP;
        sdram_addr  = 15'h0;
        sdram_dq_oe = 1'b0;
        sdram_dq    = 16'h0;
        case (state_q)
            ST_INIT: begin
                state_d    = init_end ? ST_ARBIT : ST_INIT;
                sdram_cmd  = init_cmd;
                sdram_addr = init_addr;
            end
            ST_ARBIT: state_d = aref_req ? ST_AREF : wr_req ? ST_WRITE : rd_req ? ST_READ : ST_ARBIT;
            ST_AREF: begin
                state_d    = aref_end ? ST_ARBIT : ST_AREF;
                sdram_cmd  = aref_cmd;
                sdram_addr = aref_addr;
            end
            ST_WRITE: begin
                state_d     = wr_end ? ST_ARBIT : ST_WRITE;
                sdram_cmd   = wr_cmd;
                sdram_addr  = wr_addr;
                sdram_dq_oe = wr_dq_oe;
                sdram_dq    = wr_dq;
            end
            ST_READ: begin
                state_d    = rd_end ? ST_ARBIT : ST_READ;
                sdram_cmd  = rd_cmd;
                sdram_addr = rd_addr;
            end
            default: state_d = ST_INIT;
        endcase
    end

    assign aref_en   = aref_en_q;
    assign wr_en     = wr_en_q;
    assign rd_en     = rd_en_q;
    assign sdram_cke = 1'b1;
endmodule

// File: tb/tb_sdram_arbit.sv
// tb_sdram_arbit: directed scoreboard bench for the SDRAM arbiter
module tb_sdram_arbit;
    localparam int W_INIT = 0, W_ARBIT = 1, W_AREF = 2, W_WR = 3, W_RD = 4;

    logic        clk = 1'b0, rstn = 1'b0;
    logic        init_end = 1'b0, aref_req = 1'b0, aref_end = 1'b0;
    logic        wr_req = 1'b0, wr_end = 1'b0, rd_req = 1'b0, rd_end = 1'b0;
    logic [3:0]  init_cmd = 4'h1, aref_cmd = 4'h2, wr_cmd = 4'h3, rd_cmd = 4'h4;
    logic [14:0] init_addr = 15'h1111, aref_addr = 15'h2222, wr_addr = 15'h3333, rd_addr = 15'h4444;
    logic        wr_dq_oe = 1'b1;
    logic [15:0] wr_dq = 16'hA5A5;
    logic        aref_en, wr_en, rd_en, sdram_cke, sdram_dq_oe;
    logic [3:0]  sdram_cmd;
    logic [14:0] sdram_addr;
    logic [15:0] sdram_dq;

    logic [39:0] sb[$];
    int n_chk = 0, n_fail = 0;

    always #5 clk = ~clk;

    sdram_arbit dut (
        .clk(clk), .rstn(rstn), .init_end(init_end), .init_cmd(init_cmd), .init_addr(init_addr),
        .aref_req(aref_req), .aref_end(aref_end), .aref_cmd(aref_cmd), .aref_addr(aref_addr),
        .wr_req(wr_req), .wr_end(wr_end), .wr_cmd(wr_cmd), .wr_addr(wr_addr),
        .wr_dq_oe(wr_dq_oe), .wr_dq(wr_dq),
        .rd_req(rd_req), .rd_end(rd_end), .rd_cmd(rd_cmd), .rd_addr(rd_addr),
        .aref_en(aref_en), .wr_en(wr_en), .rd_en(rd_en), .sdram_cke(sdram_cke),
        .sdram_cmd(sdram_cmd), .sdram_addr(sdram_addr), .sdram_dq_oe(sdram_dq_oe), .sdram_dq(sdram_dq)
    );

    // Expected {aref_en, wr_en, rd_en, cke, cmd, addr, dq_oe, dq} with a given owner of the bus
    function automatic logic [39:0] exp_out(input int who);
        case (who)
            W_INIT:  return {3'b000, 1'b1, init_cmd, init_addr, 1'b0, 16'h0};
            W_AREF:  return {3'b100, 1'b1, aref_cmd, aref_addr, 1'b0, 16'h0};
            W_WR:    return {3'b010, 1'b1, wr_cmd, wr_addr, wr_dq_oe, wr_dq};
            W_RD:    return {3'b001, 1'b1, rd_cmd, rd_addr, 1'b0, 16'h0};
            default: return {3'b000, 1'b1, 4'b0111, 15'h0, 1'b0, 16'h0};
        endcase
    endfunction

    task automatic check(input string tag);
        logic [39:0] obs, e;
        obs = {aref_en, wr_en, rd_en, sdram_cke, sdram_cmd, sdram_addr, sdram_dq_oe, sdram_dq};
        e = sb.pop_front();
        n_chk++;
        assert (obs === e) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, e);
        end
    endtask

    task automatic tick(input int who, input string tag);
        @(posedge clk);
        #1;
        sb.push_back(exp_out(who));
        check(tag);
    endtask

    initial begin
        #2;
        sb.push_back(exp_out(W_INIT));
        check("reset");
        @(negedge clk) rstn = 1'b1;
        repeat (200) tick(W_INIT, "init_wait");
        init_end = 1'b1;
        tick(W_ARBIT, "init_done");
        init_end = 1'b0;
        tick(W_ARBIT, "idle");
        init_end = 1'b1;
        tick(W_ARBIT, "init_end_ignored");
        aref_req = 1'b1; wr_req = 1'b1; rd_req = 1'b1;
        tick(W_AREF, "aref_wins");
        aref_req = 1'b0;
        tick(W_AREF, "aref_hold");
        wr_end = 1'b1; rd_end = 1'b1;
        tick(W_AREF, "foreign_end_ignored");
        wr_end = 1'b0; rd_end = 1'b0;
        aref_end = 1'b1;
        tick(W_ARBIT, "aref_done");
        aref_end = 1'b0;
        tick(W_WR, "wr_wins");
        wr_req = 1'b0;
        tick(W_WR, "wr_cyc2");
        aref_req = 1'b1;
        repeat (6) tick(W_WR, "wr_no_preempt");
        wr_end = 1'b1;
        tick(W_ARBIT, "wr_done");
        wr_end = 1'b0;
        tick(W_AREF, "aref_over_rd");
        aref_req = 1'b0;
        aref_end = 1'b1;
        tick(W_ARBIT, "aref_done2");
        aref_end = 1'b0;
        tick(W_RD, "rd_wins");
        rd_req = 1'b0;
        tick(W_RD, "rd_dq_blocked");
        #2 rstn = 1'b0;
        #1;
        sb.push_back(exp_out(W_INIT));
        check("async_rst");
        init_end = 1'b0;
        wr_req = 1'b1;
        @(negedge clk) rstn = 1'b1;
        repeat (5) tick(W_INIT, "post_rst_no_grant");
        init_end = 1'b1;
        tick(W_ARBIT, "reinit_done");
        tick(W_WR, "reinit_wr");
        wr_req = 1'b0;
        rd_req = 1'b1;
        tick(W_WR, "wr_rd_pending");
        rd_req = 1'b0;
        wr_end = 1'b1;
        tick(W_ARBIT, "wr_done2");
        wr_end = 1'b0;
        tick(W_ARBIT, "dropped_req");
        tick(W_ARBIT, "dropped_req2");
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
